mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer that sits directly upstream of the csea16 16-bit carry-select adder core.
- Accepts NWORDS operand word pairs per transaction, least-significant word first, over a valid/ready stream.
- Drives each pair into one csea16 instance and chains the carry between words through a register.
- Emits registered sum words on an output valid/ready stream, with final carry-out and signed overflow on the last word.

Parameters:
- NWORDS, 4, 16-bit words per transaction (2..16); default gives a 64-bit add.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operand pair.
- a_word  input  16  operand A word.
- b_word  input  16  operand B word.
- sub  input  1  1 = A-B; sampled on first word of a transaction only.
- cin  input  1  external carry-in; sampled on first word only, ignored when sub=1.
- out_valid  output  1  sum word valid.
- out_ready  input  1  downstream accepts sum word.
- sum_word  output  16  result word.
- out_last  output  1  sum_word is most-significant word of the transaction.
- cout  output  1  final carry-out; valid only with out_last.
- ovf  output  1  signed overflow; valid only with out_last.

Behaviour:
- Reset (asynchronous, reset_n=0): out_valid=0, sum_word=0, out_last=0, cout=0, ovf=0, word counter=0, carry register=0, mode register=0. in_ready=1 once reset releases.
- Handshakes:
  - Input accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (single output register, full throughput, no combinational path from in_valid to in_ready).
  - Outputs hold stable while out_valid && !out_ready.
- Counter FSM, counter 0..NWORDS-1; count==0 is IDLE, anything else is BUSY.
  - On accept at count 0: latch sub into the mode register. Adder carry-in = sub ? 1 : cin.
  - On accept at count>0: adder carry-in = carry register; the mode register supplies sub.
  - Adder B operand = mode ? ~b_word : b_word. At count 0 the live sub input is used in place of the mode register.
  - On every accept: sum, carry and flags are registered; carry register <= adder carry-out.
  - Counter increments on accept; wraps to 0 after NWORDS-1, which closes the transaction. The next accept starts a fresh transaction with no state carried over.
- Latency: sum_word appears one cycle after accept. Back-to-back accepts give one word per cycle.
- Last word (count==NWORDS-1 at accept): out_last=1 and cout=adder carry-out.
  - For subtract, cout=1 means no borrow.
  - ovf = (a15 == b'15) && (s15 != a15), where b' is the possibly inverted B word.
  - out_last, cout and ovf are 0 on non-last words.
- Simultaneous output transfer and input accept in the same cycle: the output register is loaded with the new word and out_valid stays 1.
- Output transfer with no accept: out_valid <= 0.
- Input stalls mid-transaction (in_valid=0): counter, carry and mode hold indefinitely.
- Reset asserted mid-transaction discards the partial transaction; the first accept after release is word 0.
- Changes on sub or cin while count>0 have no effect.

Test Plan:
- NWORDS=4, sub=0, cin=0, A=0x0000_0000_0000_FFFF, B=0x0000_0000_0000_0001 (4 words, LSW first) -> sums 0x0000, 0x0001, 0x0000, 0x0000; out_last on the 4th word only; cout=0, ovf=0.
- Add A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 -> all words 0x0000, cout=1, ovf=0. Repeat with cin=1 and B=0 -> same result.
- Subtract A=0x0, B=0x1 -> all words 0xFFFF, cout=0 (borrow), ovf=0. Subtract A=0x8000_0000_0000_0000, B=0x1 -> 0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Backpressure: out_ready=0 for 3 cycles after the first sum word while in_valid=1 -> in_ready=0, sum_word held at its value, no word lost or duplicated. Check full-rate streaming of two back-to-back transactions when out_ready=1.
- Toggle sub and cin during words 1..3 -> result identical to the undisturbed transaction.
- Assert reset_n=0 after word 2 of 4 -> out_valid=0 immediately. After release, a fresh add of 0x1+0x1 -> first word 0x0002, no carry leaked from the aborted transaction.

Source files
------------

// File: rtl/mp_add_seq_if.sv
// Operand-in / sum-out stream bundle for the multi-precision add/subtract sequencer.
// master = the producer of operands and the consumer of sums; slave = the sequencer.
interface mp_add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_word;
  logic [15:0] b_word;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_word;
  logic        out_last;
  logic        cout;
  logic        ovf;

  modport master (
    output in_valid, a_word, b_word, sub, cin, out_ready,
    input  in_ready, out_valid, sum_word, out_last, cout, ovf
  );

  modport slave (
    input  in_valid, a_word, b_word, sub, cin, out_ready,
    output in_ready, out_valid, sum_word, out_last, cout, ovf
  );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams NWORDS 16-bit operand pairs
// (LSW first) through one 16-bit carry-select adder, chaining the carry through
// a register and emitting one registered sum word per accepted pair.

// 16-bit carry-select adder: 4-bit blocks precompute both carry-in cases.
module csea16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [4:0] r0 [4];
  logic [4:0] r1 [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_blk
      assign r0[gi] = {1'b0, a[4*gi +: 4]} + {1'b0, b[4*gi +: 4]};
      assign r1[gi] = {1'b0, a[4*gi +: 4]} + {1'b0, b[4*gi +: 4]} + 5'd1;
    end
  endgenerate

  // Carry ripples only through the select muxes, not through the block adders.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[4*i +: 4] = c ? r1[i][3:0] : r0[i][3:0];
      c             = c ? r1[i][4]   : r0[i][4];
    end
    cout = c;
  end
endmodule

module mp_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mp_add_seq_if.slave   bus
);
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  // Word counter doubles as the sequencer state: zero means no transaction open.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [CW-1:0] count_reg;
  logic          carry_reg;
  logic          mode_reg;
  logic          out_valid_reg;
  logic [15:0]   sum_reg;
  logic          last_reg;
  logic          cout_reg;
  logic          ovf_reg;

  logic [0:0]    state;
  logic          accept;
  logic          is_last;
  logic          mode_eff;
  logic          carry_in;
  logic [15:0]   b_eff;
  logic [15:0]   add_sum;
  logic          add_cout;
  logic          add_ovf;
  logic [CW-1:0] count_next;

  assign state = (count_reg == '0) ? ST_IDLE : ST_BUSY;

  // Single output register: a new word may enter whenever the held one leaves.
  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_last      = (count_reg == LAST_IDX);

  // The first word of a transaction takes mode and carry from the live inputs.
  assign mode_eff = (state == ST_IDLE) ? bus.sub : mode_reg;
  assign carry_in = (state == ST_IDLE) ? (bus.sub | bus.cin) : carry_reg;
  assign b_eff    = mode_eff ? ~bus.b_word : bus.b_word;

  csea16 u_adder (
    .a    (bus.a_word),
    .b    (b_eff),
    .cin  (carry_in),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign add_ovf    = (bus.a_word[15] == b_eff[15]) && (add_sum[15] != bus.a_word[15]);
  assign count_next = is_last ? '0 : count_reg + CW'(1);

  // Sequencer state and output register update on accept / transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg     <= '0;
      carry_reg     <= 1'b0;
      mode_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      last_reg      <= 1'b0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (accept) begin
      count_reg     <= count_next;
      carry_reg     <= add_cout;
      if (state == ST_IDLE) begin
        mode_reg <= bus.sub;
      end
      out_valid_reg <= 1'b1;
      sum_reg       <= add_sum;
      last_reg      <= is_last;
      cout_reg      <= is_last && add_cout;
      ovf_reg       <= is_last && add_ovf;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.sum_word  = sum_reg;
  assign bus.out_last  = last_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq (NWORDS=4): a 64-bit arithmetic reference model fills an
// expected-word queue per transaction; a negedge monitor checks every valid word.
module tb_mp_add_seq;
  localparam int NW = 4;

  typedef struct packed {
    logic [15:0] s;
    logic        l;
    logic        c;
    logic        o;
  } exp_t;

  logic clk;
  logic reset_n;
  mp_add_seq_if bus ();

  mp_add_seq #(.NWORDS(NW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_cmp;
  int   n_bad;
  int   cyc;
  exp_t exp_q[$];
  bit   ready_mode;
  bit   ready_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Whole-number reference: the transaction is one 64-bit add of A and B (or ~B+1).
  function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                    input logic sb, input logic ci,
                                    output logic [63:0] s, output logic co, output logic ov);
    logic [64:0] r;
    logic [63:0] bp;
    bp = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, bp} + 65'(sb ? 1'b1 : ci);
    s  = r[63:0];
    co = r[64];
    ov = (a[63] == bp[63]) && (s[63] != a[63]);
  endfunction

  // out_ready source: random in ready_mode, otherwise the forced level.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Compare process: every cycle a word is presented it must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("in_ready_rule", {63'd0, bus.in_ready}, {63'd0, (!bus.out_valid || bus.out_ready)});
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {48'd0, bus.sum_word}, 64'hDEAD_0000_0000_0000);
          end else begin
            chk("sum_word", {48'd0, bus.sum_word}, {48'd0, exp_q[0].s});
            chk("out_last", {63'd0, bus.out_last}, {63'd0, exp_q[0].l});
            chk("cout",     {63'd0, bus.cout},     {63'd0, exp_q[0].c});
            chk("ovf",      {63'd0, bus.ovf},      {63'd0, exp_q[0].o});
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send_txn(input logic [63:0] a, input logic [63:0] b, input logic sb,
                          input logic ci, input int nw, input bit disturb, input int maxgap);
    logic [63:0] s;
    logic co, ov;
    ref_model(a, b, sb, ci, s, co, ov);
    for (int w = 0; w < NW; w++) begin
      exp_q.push_back('{s: s[16*w +: 16], l: (w == NW - 1), c: (w == NW - 1) && co,
                        o: (w == NW - 1) && ov});
    end
    $display("txn a=%016h b=%016h sub=%0d cin=%0d words=%0d disturb=%0d -> s=%016h cout=%0d ovf=%0d",
             a, b, sb, ci, nw, disturb, s, co, ov);
    for (int w = 0; w < nw; w++) begin
      bit acc;
      int t;
      if (maxgap > 0) begin
        int gap;
        gap = $urandom_range(0, maxgap);
        bus.in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.a_word   = a[16*w +: 16];
      bus.b_word   = b[16*w +: 16];
      bus.sub      = (w > 0 && disturb) ? 1'($urandom) : sb;
      bus.cin      = (w > 0 && disturb) ? 1'($urandom) : ci;
      t = 0;
      do begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 200);
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_words_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s;
    logic co, ov;
    int c0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    ready_mode = 1'b0; ready_force = 1'b1;
    bus.in_valid = 1'b0; bus.a_word = '0; bus.b_word = '0; bus.sub = 1'b0; bus.cin = 1'b0;

    // Pin the reference model with hand-computed results.
    ref_model(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, s, co, ov);
    chk("model_carry_word", s, 64'h0000_0000_0001_0000);
    chk("model_carry_cout", {62'd0, co, ov}, 64'd0);
    ref_model(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, s, co, ov);
    chk("model_wrap", {s[62:0], co}, 64'h1);
    ref_model(64'h0, 64'h1, 1'b1, 1'b0, s, co, ov);
    chk("model_borrow", s, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_borrow_cout", {62'd0, co, ov}, 64'd0);
    ref_model(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, s, co, ov);
    chk("model_sub_ovf", s, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("model_sub_ovf_flags", {62'd0, co, ov}, 64'd3);

    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {bus.out_valid, bus.sum_word, bus.out_last, bus.cout, bus.ovf}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Directed vectors.
    send_txn(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, NW, 1'b0, 0);
    send_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, NW, 1'b0, 0);
    send_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, NW, 1'b0, 0);
    send_txn(64'h0, 64'h1, 1'b1, 1'b0, NW, 1'b0, 0);
    send_txn(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, NW, 1'b0, 0);
    drain();

    // Full-rate streaming: two transactions in eight consecutive cycles.
    c0 = cyc;
    send_txn(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, NW, 1'b0, 0);
    send_txn(64'h7FFF_0000_FFFF_0001, 64'h0001_FFFF_0000_FFFF, 1'b1, 1'b0, NW, 1'b0, 0);
    chk("stream_cycles", 64'(cyc - c0), 64'(2 * NW));
    drain();

    // Backpressure: hold out_ready low for three cycles after the first word.
    ready_force = 1'b0;
    @(posedge clk);
    #2;
    fork
      send_txn(64'hAAAA_5555_FFFF_8001, 64'h5555_AAAA_0001_7FFF, 1'b0, 1'b0, NW, 1'b0, 0);
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!bus.out_valid && t < 50);
        chk("bp_first_word_seen", {63'd0, bus.out_valid}, 64'd1);
        repeat (3) begin
          chk("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
          @(negedge clk);
        end
        ready_force = 1'b1;
      end
    join
    drain();

    // Toggling sub/cin after the first word must not change the result.
    send_txn(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, NW, 1'b1, 0);
    send_txn(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b0, 1'b1, NW, 1'b1, 1);
    drain();

    // Reset mid-transaction after word 2 of 4.
    send_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 2, 1'b0, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_txn(64'h1, 64'h1, 1'b0, 1'b0, NW, 1'b0, 0);
    drain();

    // Randomized transactions with random gaps and random backpressure.
    ready_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) ra[63:48] = 16'h8000;
      if (i % 7 == 0) rb = ~ra;
      send_txn(ra, rb, 1'($urandom), 1'($urandom), NW, 1'($urandom), 2);
    end
    ready_mode = 1'b0;
    ready_force = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
